spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_if.sv | 25 ++
 rtl/spi_half_tick.sv | 39 +++
 rtl/spi_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame layout, peripheral register map and the
// controller state encoding, reused by both ends of the link.
package spi_pkg;

  localparam int SPI_FRAME_W   = 16;
  localparam int SPI_ADDR_W    = 7;
  localparam int SPI_DATA_W    = 8;
  localparam int SPI_WRITE_BIT = 15;

  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;
  localparam logic [SPI_ADDR_W-1:0] MAX_VALID_ADDR  = 7'd4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } spi_state_e;

  // Write frame: write flag in the MSB, then address, then data.
  function automatic logic [SPI_FRAME_W-1:0] buildFrame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    logic [SPI_FRAME_W-1:0] frame;
    frame                = {1'b0, addr, data};
    frame[SPI_WRITE_BIT] = 1'b1;
    return frame;
  endfunction

endpackage

// File: rtl/spi_if.sv
// Request/response bus plus SPI pins of the controller. The requester
// uses the master modport, the controller the slave modport.
interface spi_if;
  import spi_pkg::*;

  logic                  start;
  logic [SPI_ADDR_W-1:0] addr;
  logic [SPI_DATA_W-1:0] wdata;
  logic                  ready;
  logic                  done;
  logic                  sclk;
  logic                  copi;
  logic                  ncs;

  modport master (
    output start, addr, wdata,
    input  ready, done, sclk, copi, ncs
  );

  modport slave (
    input  start, addr, wdata,
    output ready, done, sclk, copi, ncs
  );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: an 8-bit down-counter that pulses tick_o on the last
// cycle of every SCLK half-period. load_i restarts a fresh half-period.
module spi_half_tick #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = en_i && (cnt_q == 8'd0);

  // Next count: restart on load, otherwise count down and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: sends one 16-bit frame per accepted
// request, then keeps nCS high for a programmable gap before going idle.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_DIV   = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic clk,
  input  logic rst_n,
  spi_if.slave bus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_HALVES - 1);

  spi_state_e             state_q;
  logic [SPI_FRAME_W-1:0] shreg_q;
  logic [4:0]             bitCnt_q;
  logic [3:0]             gapCnt_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   sclk_q;
  logic                   copi_q;
  logic                   ncs_q;

  logic                   tick;
  logic                   accept;
  logic [SPI_FRAME_W-1:0] frameIn;

  assign accept  = (state_q == IDLE) && bus.start;
  assign frameIn = buildFrame(bus.addr, bus.wdata);

  spi_half_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_half_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.copi  = copi_q;
  assign bus.ncs   = ncs_q;

  // Frame FSM with all pin and handshake outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitCnt_q <= 5'd0;
      gapCnt_q <= 4'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
      ncs_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= SETUP;
            shreg_q  <= frameIn;
            bitCnt_q <= 5'd0;
            gapCnt_q <= 4'd0;
            ready_q  <= 1'b0;
            ncs_q    <= 1'b0;
            copi_q   <= frameIn[SPI_FRAME_W-1];
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT_HI;
            sclk_q  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bitCnt_q == 5'd15) begin
              state_q  <= HOLD;
              bitCnt_q <= 5'd16;
            end else begin
              state_q  <= SHIFT_LO;
              bitCnt_q <= bitCnt_q + 5'd1;
              shreg_q  <= {shreg_q[SPI_FRAME_W-2:0], 1'b0};
              copi_q   <= shreg_q[SPI_FRAME_W-2];
            end
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            state_q <= SHIFT_HI;
            sclk_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            state_q  <= GAP;
            ncs_q    <= 1'b1;
            copi_q   <= 1'b0;
            gapCnt_q <= 4'd0;
          end
        end
        GAP: begin
          if (tick) begin
            if (gapCnt_q == GAP_LAST) begin
              state_q  <= IDLE;
              gapCnt_q <= 4'd0;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              gapCnt_q <= gapCnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          sclk_q  <= 1'b0;
          copi_q  <= 1'b0;
          ncs_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
